// File: rtl/request_unit.sv
// Turns the control unit's memory-request and halt decode into held I/D memory
// requests, a single-cycle PC enable, a sticky halt, and retire/stall counters.
module request_unit #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             cu_iREN,
    input  logic             cu_dREN,
    input  logic             cu_dWEN,
    input  logic             cu_halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halt_out,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_dmem_ren;
    logic             r_dmem_wen;
    logic             r_halt;
    logic [CNT_W-1:0] r_instr_count;
    logic [CNT_W-1:0] r_stall_count;

    logic w_fetch_hit;
    logic w_mem_op;
    logic w_start_data;
    logic w_start_halt;
    logic w_retire;
    logic w_stall;
    logic w_imem_ren;

    assign w_mem_op     = cu_dREN | cu_dWEN;
    assign w_fetch_hit  = (r_state == FETCH) & ihit;
    assign w_start_halt = w_fetch_hit & cu_halt;
    assign w_start_data = w_fetch_hit & ~cu_halt & w_mem_op;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; hits that do not belong to the current state are ignored
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH: begin
                if (w_start_halt) begin
                    w_next = HALTED;
                end else if (w_start_data) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                if (dhit) begin
                    w_next = FETCH;
                end
            end
            HALTED:  w_next = HALTED;
            default: w_next = FETCH;
        endcase
    end

    // Output / event decode
    always_comb begin
        w_imem_ren = 1'b0;
        w_retire   = 1'b0;
        w_stall    = 1'b0;
        case (r_state)
            FETCH: begin
                w_imem_ren = cu_iREN;
                w_retire   = ihit & ~cu_halt & ~w_mem_op;
                w_stall    = ~ihit;
            end
            DATA: begin
                w_imem_ren = cu_iREN;
                w_retire   = dhit;
                w_stall    = ~dhit;
            end
            default: begin
                w_imem_ren = 1'b0;
                w_retire   = 1'b0;
                w_stall    = 1'b0;
            end
        endcase
    end

    // Data requests are latched at the instruction hit and held until the data hit
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_dmem_ren <= 1'b0;
            r_dmem_wen <= 1'b0;
        end else if (w_start_data) begin
            r_dmem_wen <= cu_dWEN;
            r_dmem_ren <= cu_dREN & ~cu_dWEN;
        end else if ((r_state == DATA) && dhit) begin
            r_dmem_ren <= 1'b0;
            r_dmem_wen <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_halt <= 1'b0;
        end else if (w_start_halt) begin
            r_halt <= 1'b1;
        end
    end

    // Saturating counters: hold at all-ones rather than wrap
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_instr_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_retire && (r_instr_count != {CNT_W{1'b1}})) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
            if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign imemREN     = nRST & w_imem_ren;
    assign pc_en       = nRST & w_retire;
    assign dmemREN     = r_dmem_ren;
    assign dmemWEN     = r_dmem_wen;
    assign halt_out    = r_halt;
    assign instr_count = r_instr_count;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit (CNT_W=4 so saturation is reachable):
// driver pushes model expectations per cycle, monitor pops and compares.
module tb_request_unit;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          cu_iREN = 1'b0, cu_dREN = 1'b0, cu_dWEN = 1'b0, cu_halt = 1'b0;
    logic          ihit = 1'b0, dhit = 1'b0;
    logic          imemREN, dmemREN, dmemWEN, pc_en, halt_out;
    logic [CW-1:0] instr_count, stall_count;

    request_unit #(.CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST),
        .cu_iREN(cu_iREN), .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
        .ihit(ihit), .dhit(dhit),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .pc_en(pc_en), .halt_out(halt_out),
        .instr_count(instr_count), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int  cyc;
        bit  imem, dren, dwen, pce, hlt;
        int  ic, sc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Reference model: "what is the machine doing" rather than an encoded state
    bit m_in_data, m_halted, m_ren, m_wen;
    int m_ic, m_sc;

    function automatic int sat(input int v);
        return (v > MAX) ? MAX : v;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        m_in_data = 0; m_halted = 0; m_ren = 0; m_wen = 0; m_ic = 0; m_sc = 0;
    endtask

    task automatic cycle(input bit ir, input bit dr, input bit dw, input bit h,
                         input bit ih, input bit dh);
        exp_t e;
        @(negedge CLK);
        cyc++;
        cu_iREN = ir; cu_dREN = dr; cu_dWEN = dw; cu_halt = h; ihit = ih; dhit = dh;
        e.cyc  = cyc;
        e.imem = !m_halted && ir;
        e.pce  = !m_halted && ((!m_in_data && ih && !h && !(dr || dw)) || (m_in_data && dh));
        e.dren = m_ren; e.dwen = m_wen; e.hlt = m_halted;
        e.ic   = m_ic;  e.sc   = m_sc;
        exp_q.push_back(e);
        if (m_halted) begin
            // absorbing
        end else if (!m_in_data) begin
            if (!ih)             m_sc = sat(m_sc + 1);
            else if (h)          m_halted = 1;
            else if (dr || dw) begin
                m_in_data = 1; m_wen = dw; m_ren = dr && !dw;
            end else             m_ic = sat(m_ic + 1);
        end else begin
            if (dh) begin
                m_in_data = 0; m_ren = 0; m_wen = 0; m_ic = sat(m_ic + 1);
            end else             m_sc = sat(m_sc + 1);
        end
    endtask

    // Asynchronous reset pulse between edges; outputs must clear with no clock
    task automatic do_reset();
        @(negedge CLK);
        #3;
        cu_iREN = 1; ihit = 1; dhit = 1;
        nRST = 0;
        #1;
        chk("rst_dmemREN", dmemREN, 0);
        chk("rst_dmemWEN", dmemWEN, 0);
        chk("rst_imemREN", imemREN, 0);
        chk("rst_pc_en",   pc_en,   0);
        chk("rst_halt",    halt_out, 0);
        chk("rst_icnt",    instr_count, 0);
        chk("rst_scnt",    stall_count, 0);
        $display("txn reset t=%0t", $time);
        @(posedge CLK);
        #1;
        nRST = 1;
        model_reset();
    endtask

    always @(negedge CLK) begin
        #2;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imemREN", imemREN, e.imem);
            chk("dmemREN", dmemREN, e.dren);
            chk("dmemWEN", dmemWEN, e.dwen);
            chk("pc_en",   pc_en,   e.pce);
            chk("halt",    halt_out, e.hlt);
            chk("icnt",    instr_count, e.ic);
            chk("scnt",    stall_count, e.sc);
            if (e.pce || dmemREN || dmemWEN)
                $display("txn cyc=%0d pc_en=%0b dREN=%0b dWEN=%0b halt=%0b ic=%0d sc=%0d",
                         e.cyc, pc_en, dmemREN, dmemWEN, halt_out, instr_count, stall_count);
        end
    end

    initial begin
        model_reset();
        do_reset();
        // three back-to-back ALU instructions
        repeat (3) cycle(1, 0, 0, 0, 1, 0);
        // load with two data wait cycles
        cycle(1, 1, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 1);
        cycle(1, 0, 0, 0, 0, 0);
        // store with both enables set: write wins
        cycle(1, 1, 1, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1, 0);
        // halt beats store; afterwards everything is frozen
        cycle(1, 0, 1, 1, 1, 0);
        repeat (4) cycle(1, 1, 1, 0, 1, 1);
        do_reset();
        // stall saturation, then a stray dhit in FETCH
        repeat (20) cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0, 1);
        do_reset();
        // reset in the middle of a held load
        cycle(1, 1, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0);
        do_reset();
        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            bit h;
            h = ($urandom_range(0, 19) == 0);
            cycle($urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  h, $urandom_range(0, 2) != 0, $urandom_range(0, 1));
            if (m_halted && ($urandom_range(0, 3) == 0)) do_reset();
            else if ($urandom_range(0, 59) == 0) do_reset();
        end
        @(negedge CLK);
        #4;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
